// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and IF/ID register: NOP encoding,
// register-zero index, MIPS-style operand field positions and the
// per-cycle action encodings.
package if_id_stage_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  typedef enum logic [1:0] {
    ACT_FETCH       = 2'd0,
    ACT_STALL       = 2'd1,
    ACT_REDIRECT_BR = 2'd2,
    ACT_REDIRECT_J  = 2'd3
  } action_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of the fetch-stage signals: instruction-memory port, redirect
// inputs, ID/EX hazard inputs, IF/ID outputs and debug counters.
// master = the fetch stage, slave = the surrounding pipeline/memory.
interface if_id_stage_if
  import if_id_stage_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [31:0]      pc_o;
  logic [31:0]      instr_i;
  logic             branch_taken_i;
  logic [31:0]      branch_target_i;
  logic             jump_i;
  logic [31:0]      jump_target_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [31:0]      instr_o;
  logic [31:0]      pc_plus4_o;
  logic             valid_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  action_e          last_act;

  modport master (
    output pc_o, instr_o, pc_plus4_o, valid_o, stall_o,
           stall_cnt_o, flush_cnt_o, last_act,
    input  instr_i, branch_taken_i, branch_target_i, jump_i,
           jump_target_i, idex_memread_i, idex_rt_i
  );

  modport slave (
    input  pc_o, instr_o, pc_plus4_o, valid_o, stall_o,
           stall_cnt_o, flush_cnt_o, last_act,
    output instr_i, branch_taken_i, branch_target_i, jump_i,
           jump_target_i, idex_memread_i, idex_rt_i
  );
endinterface

// File: rtl/if_id_stage_load_use_detect.sv
// Load-use hazard term: the instruction sitting in IF/ID reads a register
// that the load currently in ID/EX has not yet written.
module if_id_stage_load_use_detect
  import if_id_stage_pkg::*;
(
  input  logic       valid,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       hazard
);

  // Register zero never carries a dependency, so a load to $0 never stalls.
  assign hazard = valid & idex_memread & (idex_rt != REG_ZERO) &
                  ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID register. Owns the PC, latches the instruction
// memory output, stalls on load-use and flushes on branch/jump redirects.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 16
)(
  input  logic          clk_i,
  input  logic          rst_i,
  if_id_stage_if.master bus
);

  logic [31:0]      pc_p0;
  logic [31:0]      pc_inc_p0;
  logic [31:0]      instr_p1;
  logic [31:0]      pc_plus4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hazard;
  action_e          act_q;
  action_e          act_nxt;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  if_id_stage_load_use_detect u_hazard (
    .valid        (vld_p1),
    .idex_memread (bus.idex_memread_i),
    .idex_rt      (bus.idex_rt_i),
    .ifid_rs      (instr_p1[RS_HI:RS_LO]),
    .ifid_rt      (instr_p1[RT_HI:RT_LO]),
    .hazard       (hazard)
  );

  // PC+4 wraps modulo 2^32 with no special handling.
  assign pc_inc_p0 = pc_p0 + 32'd4;

  // Choose this cycle's action; a taken branch outranks a stall, and a
  // jump is only honoured once the stall has cleared.
  always_comb begin
    act_nxt = ACT_FETCH;
    if (bus.branch_taken_i) begin
      act_nxt = ACT_REDIRECT_BR;
    end else if (hazard) begin
      act_nxt = ACT_STALL;
    end else if (bus.jump_i && vld_p1) begin
      act_nxt = ACT_REDIRECT_J;
    end
  end

  // IF -> ID boundary: PC, IF/ID register, counters and action record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_p0       <= PC_RESET;
      instr_p1    <= NOP;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      act_q       <= ACT_FETCH;
    end else begin
      act_q <= act_nxt;
      case (act_nxt)
        ACT_REDIRECT_BR: begin
          pc_p0       <= bus.branch_target_i;
          instr_p1    <= NOP;
          pc_plus4_p1 <= 32'd0;
          vld_p1      <= 1'b0;
          flush_cnt   <= sat_inc(flush_cnt);
        end
        ACT_STALL: begin
          stall_cnt <= sat_inc(stall_cnt);
        end
        ACT_REDIRECT_J: begin
          pc_p0       <= bus.jump_target_i;
          instr_p1    <= NOP;
          pc_plus4_p1 <= 32'd0;
          vld_p1      <= 1'b0;
          flush_cnt   <= sat_inc(flush_cnt);
        end
        default: begin
          pc_p0       <= pc_inc_p0;
          instr_p1    <= bus.instr_i;
          pc_plus4_p1 <= pc_inc_p0;
          vld_p1      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_o        = pc_p0;
  assign bus.instr_o     = instr_p1;
  assign bus.pc_plus4_o  = pc_plus4_p1;
  assign bus.valid_o     = vld_p1;
  assign bus.stall_o     = hazard & ~bus.branch_taken_i;
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
  assign bus.last_act    = act_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a main instance at PC_RESET=0 and a
// second instance at PC_RESET=FFFF_FFF8 with 2-bit counters for the
// wrap and saturation corners.
module tb_if_id_stage;
  import if_id_stage_pkg::*;

  logic clk;
  logic rst;
  logic ovr;
  logic [31:0] ovr_val;
  logic br1;
  int vectors;
  int miscompares;

  if_id_stage_if #(.CNT_W(16)) bus ();
  if_id_stage_if #(.CNT_W(2))  b1 ();

  if_id_stage #(.PC_RESET(32'h0000_0000), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  if_id_stage #(.PC_RESET(32'hFFFF_FFF8), .CNT_W(2)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1.master)
  );

  // Instruction memory returns the address as data unless overridden.
  assign bus.instr_i = ovr ? ovr_val : bus.pc_o;

  assign b1.instr_i         = b1.pc_o;
  assign b1.branch_taken_i  = br1;
  assign b1.branch_target_i = 32'h0;
  assign b1.jump_i          = 1'b0;
  assign b1.jump_target_i   = 32'h0;
  assign b1.idex_memread_i  = 1'b0;
  assign b1.idex_rt_i       = 5'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    ovr = 1'b0;
    ovr_val = 32'h0;
    br1 = 1'b0;
    bus.branch_taken_i  = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.jump_i          = 1'b0;
    bus.jump_target_i   = 32'h0;
    bus.idex_memread_i  = 1'b0;
    bus.idex_rt_i       = 5'd0;

    #1;
    chk("rst_pc",       bus.pc_o,            32'h0);
    chk("rst_instr",    bus.instr_o,         32'h0);
    chk("rst_pc4",      bus.pc_plus4_o,      32'h0);
    chk("rst_valid",    32'(bus.valid_o),    32'h0);
    chk("rst_stall",    32'(bus.stall_o),    32'h0);
    chk("rst_stallcnt", 32'(bus.stall_cnt_o), 32'h0);
    chk("rst_flushcnt", 32'(bus.flush_cnt_o), 32'h0);
    chk("rst_pc1",      b1.pc_o,             32'hFFFF_FFF8);

    @(negedge clk);
    rst = 1'b0;

    // Free-running fetch
    tick();
    chk("f1_pc",    bus.pc_o,         32'h4);
    chk("f1_instr", bus.instr_o,      32'h0);
    chk("f1_pc4",   bus.pc_plus4_o,   32'h4);
    chk("f1_valid", 32'(bus.valid_o), 32'h1);
    chk("f1_act",   32'(bus.last_act), 32'(ACT_FETCH));
    chk("w1_pc",    b1.pc_o,          32'hFFFF_FFFC);
    chk("w1_instr", b1.instr_o,       32'hFFFF_FFF8);
    tick();
    chk("f2_pc",    bus.pc_o,         32'h8);
    chk("f2_instr", bus.instr_o,      32'h4);
    chk("w2_pc",    b1.pc_o,          32'h0);
    chk("w2_instr", b1.instr_o,       32'hFFFF_FFFC);
    chk("w2_pc4",   b1.pc_plus4_o,    32'h0);
    tick();
    chk("f3_pc",    bus.pc_o,         32'hC);
    chk("f3_instr", bus.instr_o,      32'h8);

    // Load-use on rs=5
    ovr_val = 32'h00A0_0000;
    ovr = 1'b1;
    tick();
    ovr = 1'b0;
    chk("lu_instr", bus.instr_o, 32'h00A0_0000);
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i = 5'd5;
    #1;
    chk("lu_stall", 32'(bus.stall_o), 32'h1);
    tick();
    chk("lu_pc_hold",    bus.pc_o,             32'h10);
    chk("lu_instr_hold", bus.instr_o,          32'h00A0_0000);
    chk("lu_stallcnt",   32'(bus.stall_cnt_o), 32'h1);
    chk("lu_act",        32'(bus.last_act),    32'(ACT_STALL));
    bus.idex_memread_i = 1'b0;
    #1;
    chk("lu_clear", 32'(bus.stall_o), 32'h0);
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i = 5'd0;
    #1;
    chk("lu_rt0", 32'(bus.stall_o), 32'h0);
    tick();
    bus.idex_memread_i = 1'b0;
    chk("lu_resume_pc",  bus.pc_o,             32'h14);
    chk("lu_resume_in",  bus.instr_o,          32'h10);
    chk("lu_stallcnt2",  32'(bus.stall_cnt_o), 32'h1);

    // Walk to pc 0x20 with a hazard instruction (rt=7) on instr_o
    tick();
    tick();
    ovr_val = 32'h0007_0000;
    ovr = 1'b1;
    tick();
    ovr = 1'b0;
    chk("br_pre_pc", bus.pc_o, 32'h20);

    // Branch and hazard together: branch wins
    bus.idex_memread_i  = 1'b1;
    bus.idex_rt_i       = 5'd7;
    bus.branch_taken_i  = 1'b1;
    bus.branch_target_i = 32'h100;
    #1;
    chk("br_stall_masked", 32'(bus.stall_o), 32'h0);
    tick();
    bus.branch_taken_i = 1'b0;
    bus.idex_memread_i = 1'b0;
    bus.idex_rt_i      = 5'd0;
    chk("br_pc",       bus.pc_o,             32'h100);
    chk("br_instr",    bus.instr_o,          32'h0);
    chk("br_pc4",      bus.pc_plus4_o,       32'h0);
    chk("br_valid",    32'(bus.valid_o),     32'h0);
    chk("br_flushcnt", 32'(bus.flush_cnt_o), 32'h1);
    chk("br_stallcnt", 32'(bus.stall_cnt_o), 32'h1);
    chk("br_act",      32'(bus.last_act),    32'(ACT_REDIRECT_BR));
    tick();
    chk("br_tgt_pc",    bus.pc_o,         32'h104);
    chk("br_tgt_instr", bus.instr_o,      32'h100);
    chk("br_tgt_valid", 32'(bus.valid_o), 32'h1);

    // Jump presented during a hazard (rs=3)
    ovr_val = 32'h0060_0000;
    ovr = 1'b1;
    tick();
    ovr = 1'b0;
    bus.idex_memread_i = 1'b1;
    bus.idex_rt_i      = 5'd3;
    bus.jump_i         = 1'b1;
    bus.jump_target_i  = 32'h40;
    #1;
    chk("j_stall", 32'(bus.stall_o), 32'h1);
    tick();
    chk("j_ign_pc",    bus.pc_o,             32'h108);
    chk("j_ign_flush", 32'(bus.flush_cnt_o), 32'h1);
    chk("j_stallcnt",  32'(bus.stall_cnt_o), 32'h2);
    bus.idex_memread_i = 1'b0;
    bus.idex_rt_i      = 5'd0;
    tick();
    bus.jump_i = 1'b0;
    chk("j_pc",    bus.pc_o,             32'h40);
    chk("j_valid", 32'(bus.valid_o),     32'h0);
    chk("j_instr", bus.instr_o,          32'h0);
    chk("j_flush", 32'(bus.flush_cnt_o), 32'h2);
    chk("j_act",   32'(bus.last_act),    32'(ACT_REDIRECT_J));
    tick();
    chk("j_tgt_pc",    bus.pc_o,       32'h44);
    chk("j_tgt_instr", bus.instr_o,    32'h40);
    chk("j_tgt_pc4",   bus.pc_plus4_o, 32'h44);

    // Asynchronous reset between clock edges
    #3;
    rst = 1'b1;
    #1;
    chk("ar_pc",       bus.pc_o,             32'h0);
    chk("ar_instr",    bus.instr_o,          32'h0);
    chk("ar_valid",    32'(bus.valid_o),     32'h0);
    chk("ar_stallcnt", 32'(bus.stall_cnt_o), 32'h0);
    chk("ar_flushcnt", 32'(bus.flush_cnt_o), 32'h0);
    chk("ar_pc1",      b1.pc_o,              32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_f1_pc",    bus.pc_o,         32'h4);
    chk("ar_f1_valid", 32'(bus.valid_o), 32'h1);

    // Counter saturation on the 2-bit instance
    br1 = 1'b1;
    tick();
    tick();
    tick();
    chk("sat_3", 32'(b1.flush_cnt_o), 32'h3);
    tick();
    chk("sat_hold", 32'(b1.flush_cnt_o), 32'h3);
    br1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
